// File: rtl/mul_ctrl_pkg.sv
// rtl/mul_ctrl_pkg.sv - op encodings, FSM states and signedness constants for the multiply issue controller
package mul_ctrl_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_MULW   = 3'b100;

  // bit1 = multiplicand signed, bit0 = multiplier signed
  localparam logic [1:0] MS_SS = 2'b11;
  localparam logic [1:0] MS_SU = 2'b10;
  localparam logic [1:0] MS_UU = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_MULW;
  endfunction

  function automatic logic [1:0] op_signedness(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULW: return MS_SS;
      OP_MULHSU:                return MS_SU;
      default:                  return MS_UU;
    endcase
  endfunction

endpackage

// File: rtl/mul_fuse_cache.sv
// rtl/mul_fuse_cache.sv - one-entry operand/result store with hit compare for MUL/MULH* fusion
module mul_fuse_cache #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_rs1,
  input  logic [XLEN-1:0] wr_rs2,
  input  logic [1:0]      wr_signed,
  input  logic [XLEN-1:0] wr_hi,
  input  logic [XLEN-1:0] wr_lo,
  input  logic            lk_en,
  input  logic [XLEN-1:0] lk_rs1,
  input  logic [XLEN-1:0] lk_rs2,
  input  logic [1:0]      lk_signed,
  input  logic            lk_any_sign,
  output logic            hit,
  output logic [XLEN-1:0] hit_hi,
  output logic [XLEN-1:0] hit_lo
);

  logic            valid;
  logic [XLEN-1:0] key_rs1;
  logic [XLEN-1:0] key_rs2;
  logic [1:0]      key_signed;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      key_rs1    <= '0;
      key_rs2    <= '0;
      key_signed <= 2'b00;
      hit_hi     <= '0;
      hit_lo     <= '0;
    end else if (wr_en) begin
      valid      <= 1'b1;
      key_rs1    <= wr_rs1;
      key_rs2    <= wr_rs2;
      key_signed <= wr_signed;
      hit_hi     <= wr_hi;
      hit_lo     <= wr_lo;
    end
  end

  // The low half of a product does not depend on signedness, so a MUL lookup ignores it
  assign hit = lk_en & valid & (key_rs1 == lk_rs1) & (key_rs2 == lk_rs2)
             & (lk_any_sign | (key_signed == lk_signed));

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - sequences one M-extension multiply at a time onto the shared Booth multiplier
module mul_issue_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit EN_CACHE = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic            perf_hit,
  output logic            mul_in_valid,
  output logic            mul_flush,
  output logic            mul_mulw,
  output logic [1:0]      mul_signed,
  output logic [XLEN-1:0] mul_multiplicand,
  output logic [XLEN-1:0] mul_multiplier,
  input  logic            mul_out_ready,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_result_hi,
  input  logic [XLEN-1:0] mul_result_lo
);

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      op_q;
  logic            accept;
  logic            req_legal;
  logic            req_mulw;
  logic [1:0]      req_signed;
  logic            lookup_en;
  logic            cache_hit;
  logic            fast_path;
  logic            capture;
  logic            cache_wr;
  logic [XLEN-1:0] hit_hi;
  logic [XLEN-1:0] hit_lo;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] sel_result(input logic [2:0]      op,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo);
    case (op)
      OP_MUL:                       return lo;
      OP_MULH, OP_MULHSU, OP_MULHU: return hi;
      OP_MULW:                      return sext32(lo);
      default:                      return '0;
    endcase
  endfunction

  assign req_ready  = (state == IDLE) & ~flush;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign accept     = req_valid & req_ready;
  assign req_legal  = op_legal(req_op);
  assign req_mulw   = (req_op == OP_MULW);
  assign req_signed = op_signedness(req_op);
  assign lookup_en  = EN_CACHE & req_legal & ~req_mulw;
  assign fast_path  = cache_hit | ~req_legal;
  assign capture    = (state == WAIT) & mul_out_valid & ~flush;
  assign cache_wr   = EN_CACHE & capture & (op_q != OP_MULW);

  // Key is the registered operand pair, which for non-MULW ops equals raw rs1/rs2
  mul_fuse_cache #(.XLEN(XLEN)) u_cache (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (cache_wr),
    .wr_rs1      (mul_multiplicand),
    .wr_rs2      (mul_multiplier),
    .wr_signed   (mul_signed),
    .wr_hi       (mul_result_hi),
    .wr_lo       (mul_result_lo),
    .lk_en       (lookup_en),
    .lk_rs1      (req_rs1),
    .lk_rs2      (req_rs2),
    .lk_signed   (req_signed),
    .lk_any_sign (req_op == OP_MUL),
    .hit         (cache_hit),
    .hit_hi      (hit_hi),
    .hit_lo      (hit_lo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mul_in_valid = 1'b0;
    mul_flush    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = fast_path ? DONE : ISSUE;
      end
      ISSUE: begin
        mul_in_valid = mul_out_ready & ~flush;
        if (mul_in_valid)  state_nxt = WAIT;
        else if (flush)    state_nxt = IDLE;
      end
      WAIT: begin
        // A result arriving together with flush is simply dropped; nothing left in flight
        if (mul_out_valid) begin
          state_nxt = flush ? IDLE : DONE;
        end else if (flush) begin
          mul_flush = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (mul_out_valid) state_nxt = IDLE;
      end
      DONE: begin
        if (flush | resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q             <= OP_MUL;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      mul_signed       <= MS_UU;
      mul_mulw         <= 1'b0;
      resp_data        <= '0;
      perf_hit         <= 1'b0;
    end else begin
      perf_hit <= accept & cache_hit;
      if (accept) begin
        op_q <= req_op;
        if (req_legal) begin
          mul_multiplicand <= req_mulw ? sext32(req_rs1) : req_rs1;
          mul_multiplier   <= req_mulw ? sext32(req_rs2) : req_rs2;
          mul_signed       <= req_signed;
          mul_mulw         <= req_mulw;
        end
        if (cache_hit)       resp_data <= sel_result(req_op, hit_hi, hit_lo);
        else if (!req_legal) resp_data <= '0;
      end
      if (capture) resp_data <= sel_result(op_q, mul_result_hi, mul_result_lo);
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - scoreboard bench for mul_issue_ctrl with a 33-cycle multiplier model
module tb_mul_issue_ctrl;

  localparam logic [2:0] T_MUL    = 3'd0;
  localparam logic [2:0] T_MULH   = 3'd1;
  localparam logic [2:0] T_MULHSU = 3'd2;
  localparam logic [2:0] T_MULHU  = 3'd3;
  localparam logic [2:0] T_MULW   = 3'd4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_rs1;
  logic [63:0] req_rs2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        busy;
  logic        perf_hit;
  logic        mul_in_valid;
  logic        mul_flush;
  logic        mul_mulw;
  logic [1:0]  mul_signed;
  logic [63:0] mul_multiplicand;
  logic [63:0] mul_multiplier;
  logic        mul_out_ready;
  logic        mul_out_valid;
  logic [63:0] mul_result_hi;
  logic [63:0] mul_result_lo;

  always #5 clock = ~clock;

  mul_issue_ctrl #(.XLEN(64), .EN_CACHE(1'b1)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_rs1          (req_rs1),
    .req_rs2          (req_rs2),
    .flush            (flush),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .busy             (busy),
    .perf_hit         (perf_hit),
    .mul_in_valid     (mul_in_valid),
    .mul_flush        (mul_flush),
    .mul_mulw         (mul_mulw),
    .mul_signed       (mul_signed),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_out_ready    (mul_out_ready),
    .mul_out_valid    (mul_out_valid),
    .mul_result_hi    (mul_result_hi),
    .mul_result_lo    (mul_result_lo)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier model: full-width product, out_valid 33 cycles after the issue cycle
  int          mcnt;
  logic [63:0] ma;
  logic [63:0] mb;
  logic [1:0]  ms;
  logic [127:0] ea;
  logic [127:0] eb;
  logic [127:0] mprod;

  assign ea = ms[1] ? {{64{ma[63]}}, ma} : {64'd0, ma};
  assign eb = ms[0] ? {{64{mb[63]}}, mb} : {64'd0, mb};
  assign mprod = ea * eb;
  assign mul_out_ready = (mcnt == 0) && !mul_out_valid;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mcnt          <= 0;
      mul_out_valid <= 1'b0;
      mul_result_hi <= 64'd0;
      mul_result_lo <= 64'd0;
      ma            <= 64'd0;
      mb            <= 64'd0;
      ms            <= 2'b00;
    end else begin
      mul_out_valid <= 1'b0;
      if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          mul_out_valid <= 1'b1;
          mul_result_hi <= mprod[127:64];
          mul_result_lo <= mprod[63:0];
        end
      end else if (mul_in_valid) begin
        mcnt <= 32;
        ma   <= mul_multiplicand;
        mb   <= mul_multiplier;
        ms   <= mul_signed;
      end
    end
  end

  // Reference: architectural result of each op from the raw register values
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    logic [127:0] p;
    logic [31:0]  w;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    case (op)
      T_MUL:    begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
      T_MULH:   begin p = sa * sb; return p[127:64]; end
      T_MULHSU: begin p = sa * $signed({64'd0, b}); return p[127:64]; end
      T_MULHU:  begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
      T_MULW:   begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
      default:  return 64'd0;
    endcase
  endfunction

  function automatic logic [1:0] ref_sign(input logic [2:0] op);
    case (op)
      T_MULHSU: return 2'b10;
      T_MULHU:  return 2'b00;
      default:  return 2'b11;
    endcase
  endfunction

  // Reference fusion cache: last completed non-MULW multiply
  bit          rc_valid = 1'b0;
  logic [63:0] rc_a;
  logic [63:0] rc_b;
  logic [1:0]  rc_s;

  typedef struct {
    logic [63:0] data;
    bit          hit;
    int          acc;
    int          lat;
    int          issues;
    int          nissue;
  } exp_t;

  exp_t exp_q[$];
  int   issue_cnt = 0;
  int   last_issue_cyc = -1;

  task automatic do_req(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit track, output int waited);
    exp_t e;
    bit legal;
    bit hit;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    waited    = 0;
    while (1) begin
      @(negedge clock);
      if (req_ready) break;
      waited++;
      if (waited > 400) begin
        chk1("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    if (waited <= 400) begin
      legal = (op <= T_MULW);
      hit = legal && (op != T_MULW) && rc_valid && (rc_a == a) && (rc_b == b)
            && ((op == T_MUL) || (rc_s == ref_sign(op)));
      e.data   = ref_result(op, a, b);
      e.hit    = hit;
      e.acc    = cyc;
      e.lat    = (hit || !legal) ? 1 : 35;
      e.issues = issue_cnt;
      e.nissue = (hit || !legal) ? 0 : 1;
      if (track) begin
        exp_q.push_back(e);
        if (!hit && legal && op != T_MULW) begin
          rc_valid = 1'b1;
          rc_a = a;
          rc_b = b;
          rc_s = ref_sign(op);
        end
      end
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((busy || exp_q.size() != 0) && n < 600);
    if (n >= 600) chk1("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_issue();
    int n = 0;
    int start = issue_cnt;
    while (issue_cnt == start && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk1("issue_timeout", 1'b0, 1'b1);
  endtask

  task automatic check_quiet(input string tag);
    chk1({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_perf_hit"}, perf_hit, 1'b0);
    chk1({tag, "_mul_in_valid"}, mul_in_valid, 1'b0);
    chk1({tag, "_mul_flush"}, mul_flush, 1'b0);
    chk1({tag, "_mul_mulw"}, mul_mulw, 1'b0);
    chkint({tag, "_mul_signed"}, int'(mul_signed), 0);
    chk64({tag, "_resp_data"}, resp_data, 64'd0);
    chk64({tag, "_multiplicand"}, mul_multiplicand, 64'd0);
    chk64({tag, "_multiplier"}, mul_multiplier, 64'd0);
    chk1({tag, "_req_ready"}, req_ready, 1'b1);
  endtask

  // Monitor / scoreboard
  bit          prev_rv = 1'b0;
  bit          prev_hs = 1'b0;
  bit          prev_miv = 1'b0;
  logic [63:0] prev_data = 64'd0;

  always @(negedge clock) begin
    if (reset) begin
      prev_rv  = 1'b0;
      prev_hs  = 1'b0;
      prev_miv = 1'b0;
    end else begin
      if (mul_in_valid) begin
        issue_cnt++;
        last_issue_cyc = cyc;
        chk1("issue_while_busy", busy, 1'b1);
        chk1("issue_single_pulse", prev_miv, 1'b0);
      end
      if (resp_valid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          chk1("unexpected_resp", resp_valid, 1'b0);
        end else begin
          chkint("resp_latency", cyc - exp_q[0].acc, exp_q[0].lat);
          chk1("perf_hit", perf_hit, exp_q[0].hit);
          chkint("issue_count", issue_cnt - exp_q[0].issues, exp_q[0].nissue);
          if (exp_q[0].nissue == 1) chkint("issue_cycle", last_issue_cyc - exp_q[0].acc, 1);
        end
      end
      if (resp_valid && prev_rv && !prev_hs) chk64("resp_stable", resp_data, prev_data);
      if (resp_valid && resp_ready && exp_q.size() != 0) begin
        chk64("resp_data", resp_data, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      prev_rv   = resp_valid;
      prev_hs   = resp_valid && resp_ready;
      prev_miv  = mul_in_valid;
      prev_data = resp_data;
    end
  end

  bit rr_rand = 1'b0;
  bit rr_fixed = 1'b1;

  always @(posedge clock) begin
    #1;
    resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_fixed;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pa;
    logic [63:0] pb;
    logic [2:0]  op;
    int k;

    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_rs1 = 64'd0;
    req_rs2 = 64'd0;
    flush = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_quiet("reset");
    reset = 1'b0;

    // MUL miss
    do_req(T_MUL, 64'd3, 64'd5, 1'b1, w);
    wait_idle();

    // MULH, then fused MUL, then MULHU miss
    do_req(T_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, w);
    wait_idle();
    do_req(T_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, w);
    wait_idle();
    do_req(T_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, w);
    wait_idle();

    // MULW operand formatting
    do_req(T_MULW, 64'hDEAD_BEEF_7FFF_FFFF, 64'd2, 1'b1, w);
    chk64("mulw_multiplicand", mul_multiplicand, 64'h0000_0000_7FFF_FFFF);
    chk1("mulw_flag", mul_mulw, 1'b1);
    wait_idle();

    // Illegal op
    do_req(3'd6, 64'd9, 64'd9, 1'b1, w);
    wait_idle();

    // Flush in WAIT
    do_req(T_MUL, 64'd21, 64'd4, 1'b0, w);
    wait_issue();
    repeat (10) @(negedge clock);
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(negedge clock);
    chk1("flush_mul_flush", mul_flush, 1'b1);
    chk1("flush_req_ready", req_ready, 1'b0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clock);
      n++;
      chk1("drain_mul_flush", mul_flush, 1'b0);
      chk1("drain_req_ready", req_ready, 1'b0);
      if (mul_out_valid) break;
    end
    if (n >= 100) chk1("drain_timeout", 1'b0, 1'b1);
    do_req(T_MULHSU, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 1'b1, w);
    chkint("post_drain_accept_wait", w, 0);
    wait_idle();

    // Backpressure
    rr_fixed = 1'b0;
    do_req(T_MUL, 64'd100, 64'd200, 1'b1, w);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk1("bp_resp_timeout", 1'b0, 1'b1);
    repeat (5) @(negedge clock);
    chk1("bp_still_valid", resp_valid, 1'b1);
    rr_fixed = 1'b1;
    wait_idle();

    // Reset mid-WAIT
    do_req(T_MUL, 64'd7, 64'd9, 1'b1, w);
    wait_idle();
    do_req(T_MULHU, 64'd11, 64'd13, 1'b0, w);
    wait_issue();
    repeat (5) @(negedge clock);
    #2;
    reset = 1'b1;
    rc_valid = 1'b0;
    #1;
    check_quiet("midreset");
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    do_req(T_MUL, 64'd7, 64'd9, 1'b1, w);
    wait_idle();

    // Randomized traffic
    rr_rand = 1'b1;
    pa = 64'd5;
    pb = 64'd6;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      op = (k < 9) ? 3'(k % 5) : 3'($urandom_range(5, 7));
      case ($urandom_range(0, 3))
        0: begin a = pa; b = pb; end
        1: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        2: begin a = 64'($urandom_range(0, 20)); b = 64'($urandom_range(0, 20)); end
        default: begin a = {$urandom, $urandom}; b = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3)); end
      endcase
      pa = a;
      pb = b;
      do_req(op, a, b, 1'b1, w);
    end
    wait_idle();
    rr_rand = 1'b0;
    chkint("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
